cpu_mem_responder: RTL

- Memory-side responder for the CPU's fetch and load/store interface.
- Owns the program counter register and a 2048 x 32 dual-port synchronous RAM.
- Port 1 serves instruction fetch (instr); port 2 serves data load/store (ram_data2).
- Consumes the CPU's sel_pc, load_pc, sel_ram_addr2, ram_addr1/2, ram_w_en1/2 and ram_in2; returns PC, instr, ram_data2 and a ready flag.

---
 rtl/cpu_mem_responder.sv | 118 +++++++++++
 1 files changed

// File: rtl/cpu_mem_responder.sv
// Program counter plus a dual-port, read-first, 1-cycle-latency RAM serving instruction fetch (port 1) and load/store (port 2).
// Optional MEM_CLEAR_EN: after reset, zero every word before raising mem_ready; otherwise ready immediately and RAM survives reset.
module cpu_mem_responder #(
  parameter int DEPTH    = 2048,
  parameter int DATA_W   = 32,
  parameter int RESET_PC = 0,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_pc,
  input  logic [1:0]        sel_pc,
  input  logic [AW-1:0]     pc_target,
  input  logic              sel_ram_addr2,
  input  logic [AW-1:0]     ram_addr1,
  input  logic              ram_w_en1,
  input  logic [DATA_W-1:0] ram_in1,
  input  logic [AW-1:0]     ram_addr2,
  input  logic              ram_w_en2,
  input  logic [DATA_W-1:0] ram_in2,
  output logic [31:0]       PC,
  output logic [DATA_W-1:0] instr,
  output logic [DATA_W-1:0] ram_data2,
  output logic              mem_ready
);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;
  localparam logic [AW-1:0] RST_PC = AW'(RESET_PC);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [0:0]        r_state;
  logic [AW-1:0]     r_pc;
  logic [DATA_W-1:0] r_instr;
  logic [DATA_W-1:0] r_data2;

  logic              w_ready;
  logic              w_wr_ok;
  logic [AW-1:0]     w_addr2;
  logic              w_clr_done;
  logic              w_clr_wr;
  logic [AW-1:0]     w_clr_addr;

`ifdef MEM_CLEAR_EN
  localparam logic [0:0] RST_STATE = ST_CLEAR;
  logic [AW-1:0] r_clr_cnt;

  // Counter stops at the last address so CLEAR can only exit once per reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_clr_cnt <= '0;
    end else if ((r_state == ST_CLEAR) && !w_clr_done) begin
      r_clr_cnt <= r_clr_cnt + 1'b1;
    end
  end

  assign w_clr_done = (r_clr_cnt == AW'(DEPTH - 1));
  assign w_clr_wr   = rst_n && (r_state == ST_CLEAR);
  assign w_clr_addr = r_clr_cnt;
`else
  localparam logic [0:0] RST_STATE = ST_RUN;
  assign w_clr_done = 1'b1;
  assign w_clr_wr   = 1'b0;
  assign w_clr_addr = '0;
`endif

  assign w_ready = (r_state == ST_RUN);
  assign w_wr_ok = rst_n && w_ready;
  assign w_addr2 = sel_ram_addr2 ? pc_target : ram_addr2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= RST_STATE;
    end else if ((r_state == ST_CLEAR) && w_clr_done) begin
      r_state <= ST_RUN;
    end
  end

  // Port 2 is written last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (w_clr_wr) begin
      r_mem[w_clr_addr] <= '0;
    end else if (w_wr_ok) begin
      if (ram_w_en1) r_mem[ram_addr1] <= ram_in1;
      if (ram_w_en2) r_mem[w_addr2]   <= ram_in2;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc <= RST_PC;
    end else if (w_ready && load_pc) begin
      case (sel_pc)
        2'b01:   r_pc <= (r_pc == AW'(DEPTH - 1)) ? '0 : r_pc + 1'b1;
        2'b10:   r_pc <= pc_target;
        2'b11:   r_pc <= RST_PC;
        default: r_pc <= r_pc;
      endcase
    end
  end

  // A writing port keeps its previous read data; reads see the pre-write word.
  always_ff @(posedge clk) begin
    if (!rst_n || !w_ready) begin
      r_instr <= '0;
      r_data2 <= '0;
    end else begin
      if (!ram_w_en1) r_instr <= r_mem[r_pc];
      if (!ram_w_en2) r_data2 <= r_mem[w_addr2];
    end
  end

  assign PC        = {{(32 - AW){1'b0}}, r_pc};
  assign instr     = r_instr;
  assign ram_data2 = r_data2;
  assign mem_ready = w_ready;

endmodule
